add_arbiter: RTL
================

Name: add_arbiter

Overview:
- Shares one registered signed adder (DIM-bit operands, sum truncated to DIM bits, fixed ADD_LAT-cycle latency, no stall input) between NREQ requesters.
- Round-robin grant, at most one operation issued per cycle. The requester ID travels with the operation through a tag pipeline matched to the adder latency.
- Results return through a small response FIFO with valid/ready backpressure. A credit rule ensures adder output is never dropped.
- Sits between requesting DSP blocks and the adder instance. Drives the adder's a/b inputs and reads back its sum.

Parameters:
- DIM, 14, operand/result width, must match the adder instance.
- NREQ, 4, number of requesters (2..16).
- ADD_LAT, 1, adder latency in clk cycles (>=1).
- RSP_DEPTH, 2, response FIFO depth; >= ADD_LAT+1 required for one result per cycle.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester grant, one-hot or zero.
- req_a  in  NREQ*DIM  operand a; requester i occupies bits [i*DIM +: DIM].
- req_b  in  NREQ*DIM  operand b; same packing as req_a.
- add_a  out  DIM  to adder input a.
- add_b  out  DIM  to adder input b.
- add_sum  in  DIM  from adder sum.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts head.
- rsp_id  out  $clog2(NREQ)  requester index of head result.
- rsp_sum  out  DIM  head result.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous assert, active-low. All state is cleared on assert.
- Reset values:
  - req_ready = 0, rsp_valid = 0, add_a = add_b = 0.
  - rsp_id = 0, rsp_sum = 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Tag pipeline and FIFO are empty; in-flight count is 0.
- Credit:
  - issue_ok = (fifo_count + inflight - pop) < RSP_DEPTH.
  - pop = rsp_valid & rsp_ready in the same cycle.
  - inflight = number of valid tag stages.
- Grant:
  - If issue_ok, scan req_valid starting at pointer+1 and wrapping modulo NREQ. The first set bit g gets req_ready[g] = 1; all other ready bits are 0.
  - req_ready depends combinationally on req_valid. Requesters must not make valid depend on ready.
  - Transfer occurs when req_valid[g] & req_ready[g]. On transfer the pointer updates to g at the clock edge; with no transfer the pointer holds.
- Adder drive:
  - add_a/add_b = req_a/req_b slice g in the grant cycle, combinationally.
  - In cycles with no grant, add_a/add_b = 0.
- Tag pipeline: ADD_LAT stages of {valid, id}. Stage 0 loads {transfer, g}.
- Push: when the last tag stage is valid, {id, add_sum} is written to the FIFO tail in that cycle. The sum is valid exactly ADD_LAT cycles after the transfer edge.
- FIFO:
  - First-word fall-through: rsp_valid = !empty, with rsp_id/rsp_sum taken from the head.
  - Push and pop in the same cycle are legal, including at full with pop. Push while full without pop cannot occur under the credit rule; the bench asserts this.
  - Pointers wrap modulo RSP_DEPTH.
- Ordering: responses come out in issue order.
- Throughput: with RSP_DEPTH >= ADD_LAT+1 and rsp_ready held high, one result per cycle.
- Arithmetic: no width handling beyond the adder; rsp_sum equals (a+b) mod 2^DIM in two's complement.
- Reset mid-operation: in-flight tags and FIFO contents are discarded and no response is emitted for them. The first response after reset comes from a post-reset grant.

Optional Feature:
- Macro: ADD_ARB_OVF_EN.
- Defined:
  - Extra output rsp_ovf (1 bit), stored per FIFO entry.
  - Operand sign bits a[DIM-1] and b[DIM-1] are carried in the tag pipeline.
  - rsp_ovf = 1 when the operand signs are equal and rsp_sum[DIM-1] differs from them (signed overflow).
  - rsp_ovf = 0 in reset and when the FIFO is empty.
- Undefined: the rsp_ovf port and its storage are absent. All other behaviour is identical.

Test Plan:
- Reset release, req_valid=0001, a0=5, b0=-3 -> req_ready=0001 on first cycle; ADD_LAT cycles later rsp_valid=1, rsp_id=0, rsp_sum=2.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1... one per cycle; responses in the same id order, no gaps after the first result.
- rsp_ready=0, all valid -> exactly RSP_DEPTH grants then req_ready=0. Raise rsp_ready -> head drains first, grants resume; no result is lost or duplicated.
- DIM=14, a=8191, b=1 -> rsp_sum=-8192 (0x2000). With ADD_ARB_OVF_EN, rsp_ovf=1. a=-8192, b=-1 -> rsp_sum=8191, rsp_ovf=1.
- Assert rst_n low with two operations in flight and FIFO holding one -> rsp_valid=0 and req_ready=0 immediately. After release the first grant goes to requester 0, and no stale response appears.

Source files
------------

// File: rtl/add_arbiter.sv
// add_arbiter
//   Round-robin arbiter sharing one registered signed adder between NREQ
//   requesters. The requester id rides a tag pipeline matched to the adder
//   latency; results are returned in issue order through a small
//   first-word-fall-through response FIFO. Issue is credit-limited so that an
//   adder result always has a FIFO slot waiting for it.
//
//   Optional build macro: ADD_ARB_OVF_EN adds a per-result signed overflow flag.
//
//   Ports:
//     clk, rst_n            clock (rising edge), asynchronous active-low reset
//     req_valid/req_ready   per-requester handshake; ready is one-hot or zero
//     req_a/req_b           packed operands, requester i at [i*DIM +: DIM]
//     add_a/add_b/add_sum   connection to the external adder
//     rsp_valid/rsp_ready   response handshake (FIFO head)
//     rsp_id/rsp_sum        requester index and sum of the head result
//     rsp_ovf               (ADD_ARB_OVF_EN only) signed overflow of head result
module add_arbiter #(
    parameter int DIM       = 14,
    parameter int NREQ      = 4,
    parameter int ADD_LAT   = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DIM-1:0]     req_a,
    input  logic [NREQ*DIM-1:0]     req_b,
    output logic [DIM-1:0]          add_a,
    output logic [DIM-1:0]          add_b,
    input  logic [DIM-1:0]          add_sum,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DIM-1:0]          rsp_sum
`ifdef ADD_ARB_OVF_EN
    ,
    output logic                    rsp_ovf
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);

    logic [IDW-1:0] ptr;
    logic           tag_v  [ADD_LAT];
    logic [IDW-1:0] tag_id [ADD_LAT];
    logic [IDW-1:0] mem_id  [RSP_DEPTH];
    logic [DIM-1:0] mem_sum [RSP_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_cnt;
`ifdef ADD_ARB_OVF_EN
    logic           tag_sa  [ADD_LAT];
    logic           tag_sb  [ADD_LAT];
    logic           mem_ovf [RSP_DEPTH];
    logic           push_ovf;
`endif

    logic           push, pop, issue_ok, gnt_any, transfer;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   scan;
    logic [31:0]    inflight, occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = tag_v[ADD_LAT-1];

    // Occupancy counts FIFO entries plus results still inside the adder, so a
    // grant is only made when a slot is guaranteed at the result's push cycle.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ADD_LAT; i++)
            inflight = inflight + 32'(tag_v[i]);
        occ      = 32'(fifo_cnt) + inflight - 32'(pop);
        issue_ok = (occ < 32'(RSP_DEPTH));
    end

    // Round-robin scan starting one past the last granted requester. Gated by
    // rst_n so ready drops immediately while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        if (rst_n && issue_ok) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                scan = {1'b0, ptr} + k[IDW:0];
                if (scan >= (IDW+1)'(NREQ))
                    scan = scan - (IDW+1)'(NREQ);
                if (!gnt_any && req_valid[scan[IDW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_id  = scan[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any)
            req_ready[gnt_id] = 1'b1;
    end

    assign transfer = |(req_valid & req_ready);
    assign add_a    = gnt_any ? req_a[gnt_id*DIM +: DIM] : '0;
    assign add_b    = gnt_any ? req_b[gnt_id*DIM +: DIM] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= IDW'(NREQ - 1);
        else if (transfer)
            ptr <= gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ADD_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
`ifdef ADD_ARB_OVF_EN
                tag_sa[i] <= 1'b0;
                tag_sb[i] <= 1'b0;
`endif
            end
        end else begin
            tag_v[0]  <= transfer;
            tag_id[0] <= gnt_id;
`ifdef ADD_ARB_OVF_EN
            tag_sa[0] <= add_a[DIM-1];
            tag_sb[0] <= add_b[DIM-1];
`endif
            for (int unsigned i = 1; i < ADD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
`ifdef ADD_ARB_OVF_EN
                tag_sa[i] <= tag_sa[i-1];
                tag_sb[i] <= tag_sb[i-1];
`endif
            end
        end
    end

`ifdef ADD_ARB_OVF_EN
    // Signed overflow: equal operand signs, result sign differs.
    assign push_ovf = (tag_sa[ADD_LAT-1] == tag_sb[ADD_LAT-1]) &&
                      (add_sum[DIM-1] != tag_sa[ADD_LAT-1]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                mem_id[i]  <= '0;
                mem_sum[i] <= '0;
`ifdef ADD_ARB_OVF_EN
                mem_ovf[i] <= 1'b0;
`endif
            end
        end else begin
            if (push) begin
                mem_id[wr_ptr]  <= tag_id[ADD_LAT-1];
                mem_sum[wr_ptr] <= add_sum;
`ifdef ADD_ARB_OVF_EN
                mem_ovf[wr_ptr] <= push_ovf;
`endif
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rsp_id  = rsp_valid ? mem_id[rd_ptr]  : '0;
    assign rsp_sum = rsp_valid ? mem_sum[rd_ptr] : '0;
`ifdef ADD_ARB_OVF_EN
    assign rsp_ovf = rsp_valid ? mem_ovf[rd_ptr] : 1'b0;
`endif

endmodule
